// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: time-multiplexed driver for an N-digit common-anode
// 7-segment display. It has its own refresh prescaler and digit scan counter.
// A staging/active double buffer swaps only at frame boundaries, so a frame
// never shows a mix of old and new digits. All outputs are registered.
module seven_seg_scan_driver #(
  parameter int N_DIGITS     = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*N_DIGITS-1:0]   value,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic [N_DIGITS-1:0]     digit_en,
  input  logic                    blank_lz,
  input  logic                    load,
  output logic [N_DIGITS-1:0]     anodes,
  output logic [6:0]              segments,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] PCNT_VIS  = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);

  logic [PW-1:0]           pcnt_reg;
  logic [IW-1:0]           idx_reg;
  logic [4*N_DIGITS-1:0]   stg_value_reg, act_value_reg;
  logic [N_DIGITS-1:0]     stg_dp_reg, act_dp_reg;
  logic [N_DIGITS-1:0]     stg_en_reg, act_en_reg;
  logic                    stg_lz_reg, act_lz_reg;
  logic                    pending_reg;
  logic [N_DIGITS-1:0]     anodes_reg, anodes_next;
  logic [6:0]              segments_reg, segments_next;
  logic                    dp_reg, dp_next;
  logic                    frame_tick_reg;

  logic                    slot_end;
  logic                    frame_end;
  logic [3:0]              nib [N_DIGITS];
  logic                    zero_from [N_DIGITS];
  logic [N_DIGITS-1:0]     blank_vec;

  assign slot_end  = (pcnt_reg == PCNT_LAST);
  assign frame_end = slot_end && (idx_reg == IDX_LAST);

  // Active-low {g,f,e,d,c,b,a} hex decode.
  function automatic logic [6:0] decode_hex(input logic [3:0] n);
    case (n)
      4'h0: decode_hex = 7'b1000000;
      4'h1: decode_hex = 7'b1111001;
      4'h2: decode_hex = 7'b0100100;
      4'h3: decode_hex = 7'b0110000;
      4'h4: decode_hex = 7'b0011001;
      4'h5: decode_hex = 7'b0010010;
      4'h6: decode_hex = 7'b0000010;
      4'h7: decode_hex = 7'b1111000;
      4'h8: decode_hex = 7'b0000000;
      4'h9: decode_hex = 7'b0010000;
      4'hA: decode_hex = 7'b0001000;
      4'hB: decode_hex = 7'b0000011;
      4'hC: decode_hex = 7'b1000110;
      4'hD: decode_hex = 7'b0100001;
      4'hE: decode_hex = 7'b0000110;
      default: decode_hex = 7'b0001110;
    endcase
  endfunction

  // Per-digit blanking from the active set. zero_from[i] means digit i and
  // every digit above it are zero; digit 0 is never leading-zero blanked.
  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
      assign nib[gi] = act_value_reg[4*gi +: 4];
      if (gi == N_DIGITS - 1) begin : g_top
        assign zero_from[gi] = (nib[gi] == 4'd0);
      end else begin : g_mid
        assign zero_from[gi] = (nib[gi] == 4'd0) && zero_from[gi+1];
      end
      if (gi == 0) begin : g_lsd
        assign blank_vec[gi] = ~act_en_reg[gi];
      end else begin : g_upper
        assign blank_vec[gi] = ~act_en_reg[gi] | (act_lz_reg & zero_from[gi]);
      end
    end
  endgenerate

  // Prescaler and digit scan counter; idx wraps explicitly so it never
  // exceeds N_DIGITS-1 for non-power-of-two digit counts.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pcnt_reg <= '0;
      idx_reg  <= '0;
    end else if (slot_end) begin
      pcnt_reg <= '0;
      idx_reg  <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IW'(1);
    end else begin
      pcnt_reg <= pcnt_reg + PW'(1);
    end
  end

  // Double buffer: load writes staging; staging is promoted only at the
  // frame boundary. A load on the boundary edge stays pending for the next.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stg_value_reg <= '0;
      stg_dp_reg    <= '0;
      stg_en_reg    <= '0;
      stg_lz_reg    <= 1'b0;
      act_value_reg <= '0;
      act_dp_reg    <= '0;
      act_en_reg    <= '0;
      act_lz_reg    <= 1'b0;
      pending_reg   <= 1'b0;
    end else begin
      if (frame_end && pending_reg) begin
        act_value_reg <= stg_value_reg;
        act_dp_reg    <= stg_dp_reg;
        act_en_reg    <= stg_en_reg;
        act_lz_reg    <= stg_lz_reg;
      end
      if (load) begin
        stg_value_reg <= value;
        stg_dp_reg    <= dp_in;
        stg_en_reg    <= digit_en;
        stg_lz_reg    <= blank_lz;
        pending_reg   <= 1'b1;
      end else if (frame_end) begin
        pending_reg   <= 1'b0;
      end
    end
  end

  // Next output pattern for the current scan position.
  always_comb begin
    anodes_next   = '1;
    segments_next = 7'b1111111;
    dp_next       = 1'b1;
    if ((pcnt_reg >= PCNT_VIS) && !blank_vec[idx_reg]) begin
      anodes_next[idx_reg] = 1'b0;
      segments_next        = decode_hex(nib[idx_reg]);
      dp_next              = ~act_dp_reg[idx_reg];
    end
  end

  // Registered pin drivers; frame_tick marks the cycle after the wrap edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      anodes_reg     <= '1;
      segments_reg   <= 7'b1111111;
      dp_reg         <= 1'b1;
      frame_tick_reg <= 1'b0;
    end else begin
      anodes_reg     <= anodes_next;
      segments_reg   <= segments_next;
      dp_reg         <= dp_next;
      frame_tick_reg <= frame_end;
    end
  end

  assign anodes     = anodes_reg;
  assign segments   = segments_reg;
  assign dp         = dp_reg;
  assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver (4 digits, 4-cycle slots, 1 blank
// cycle). Expected per-cycle outputs are queued per frame and popped each cycle.
module tb_seven_seg_scan_driver;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        blank_lz;
  logic        load;
  logic [3:0]  anodes;
  logic [6:0]  segments;
  logic        dp;
  logic        frame_tick;

  int checks = 0;
  int fails  = 0;
  string tag = "init";
  logic [12:0] exp_q [$];

  seven_seg_scan_driver #(
    .N_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .value(value), .dp_in(dp_in),
    .digit_en(digit_en), .blank_lz(blank_lz), .load(load),
    .anodes(anodes), .segments(segments), .dp(dp), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[n];
  endfunction

  // Queue the 16 output cycles following a frame_tick cycle for the given
  // active contents: per slot one blank cycle then three visible cycles.
  task automatic push_frame(input logic [15:0] v, input logic [3:0] en,
                            input logic [3:0] dpi, input logic lz);
    logic       seen;
    logic [3:0] blk;
    logic [3:0] n;
    logic [12:0] e;
    seen = 1'b0;
    for (int d = 3; d >= 0; d--) begin
      n = v[4*d +: 4];
      blk[d] = !en[d] || (lz && d != 0 && !seen && n == 4'd0);
      if (n != 4'd0) seen = 1'b1;
    end
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 4; k++) begin
        e = {4'hF, 7'h7F, 1'b1, 1'b0};
        if (k != 0 && !blk[s])
          e = {~(4'b0001 << s), seg_of(v[4*s +: 4]), ~dpi[s], 1'b0};
        if (s == 3 && k == 3) e[0] = 1'b1;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] en,
                         input logic [3:0] dpi, input logic lz);
    value = v; digit_en = en; dp_in = dpi; blank_lz = lz; load = 1'b1;
  endtask

  // Advance n cycles; compare {anodes,segments,dp,frame_tick} each cycle.
  task automatic run_cycles(input int n);
    logic [12:0] obs;
    logic [12:0] expv;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      load = 1'b0;
      obs = {anodes, segments, dp, frame_tick};
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $error("FAIL %s: no expected entry, observed %h", tag, obs);
      end else begin
        expv = exp_q.pop_front();
        assert (obs === expv) else begin
          fails++;
          $error("FAIL %s: {an,seg,dp,tick} observed %h expected %h", tag, obs, expv);
        end
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; value = '0; dp_in = '0; digit_en = '0; blank_lz = 1'b0; load = 1'b0;
    repeat (2) @(negedge clk);

    tag = "reset_values";
    exp_q.push_back({4'hF, 7'h7F, 1'b1, 1'b0});
    run_cycles(1);
    reset_n = 1'b1;

    tag = "reset_scan";
    push_frame(16'h0000, 4'h0, 4'h0, 1'b0);
    push_frame(16'h0000, 4'h0, 4'h0, 1'b0);
    run_cycles(32);

    tag = "basic";
    do_load(16'h12AF, 4'hF, 4'b0100, 1'b0);
    push_frame(16'h0000, 4'h0, 4'h0, 1'b0);
    run_cycles(16);
    push_frame(16'h12AF, 4'hF, 4'b0100, 1'b0);
    run_cycles(16);

    tag = "lz_0040";
    do_load(16'h0040, 4'hF, 4'h0, 1'b1);
    push_frame(16'h12AF, 4'hF, 4'b0100, 1'b0);
    run_cycles(16);
    push_frame(16'h0040, 4'hF, 4'h0, 1'b1);
    run_cycles(16);

    tag = "lz_0000";
    do_load(16'h0000, 4'hF, 4'h0, 1'b1);
    push_frame(16'h0040, 4'hF, 4'h0, 1'b1);
    run_cycles(16);
    push_frame(16'h0000, 4'hF, 4'h0, 1'b1);
    run_cycles(16);

    tag = "tear_free";
    do_load(16'h1111, 4'hF, 4'h0, 1'b0);
    push_frame(16'h0000, 4'hF, 4'h0, 1'b1);
    run_cycles(15);
    do_load(16'h2222, 4'hF, 4'h0, 1'b0);
    run_cycles(1);
    push_frame(16'h1111, 4'hF, 4'h0, 1'b0);
    run_cycles(16);
    push_frame(16'h2222, 4'hF, 4'h0, 1'b0);
    run_cycles(16);

    tag = "multi_load";
    push_frame(16'h2222, 4'hF, 4'h0, 1'b0);
    run_cycles(3);
    do_load(16'h3333, 4'hF, 4'h0, 1'b0);
    run_cycles(4);
    do_load(16'h4444, 4'hF, 4'h0, 1'b0);
    run_cycles(9);
    push_frame(16'h4444, 4'hF, 4'h0, 1'b0);
    run_cycles(16);

    tag = "mid_reset";
    do_load(16'h5555, 4'hF, 4'hF, 1'b0);
    push_frame(16'h4444, 4'hF, 4'h0, 1'b0);
    run_cycles(9);
    exp_q.delete();
    reset_n = 1'b0;
    exp_q.push_back({4'hF, 7'h7F, 1'b1, 1'b0});
    run_cycles(1);
    reset_n = 1'b1;
    tag = "post_reset";
    push_frame(16'h0000, 4'h0, 4'h0, 1'b0);
    push_frame(16'h0000, 4'h0, 4'h0, 1'b0);
    run_cycles(32);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
